fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequences the byte-addressed 512-byte instruction ROM for the core front end. Owns the fetch PC and drives the ROM address, advancing it by 4 per fetched word. Captures each 32-bit word with its PC into a small queue and presents it to decode over a valid/ready handshake. Also absorbs stalls and branch/jump redirects from the execute stage.

## Interface
Parameters:
- ADDR_W, 9, byte-address width of the instruction ROM
- INSTR_W, 32, instruction width
- QDEPTH, 2, queue entries; power of two, at least 2
- RESET_PC, 9'h000, fetch PC after reset; word aligned

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- fetch_en  input  1  enables fetching; when low the PC holds and nothing is enqueued
- imem_addr  output  ADDR_W  ROM byte address; always equal to the fetch PC
- imem_instr  input  INSTR_W  combinational ROM read data for imem_addr
- redirect_valid  input  1  one-cycle request to flush the queue and restart at redirect_pc
- redirect_pc  input  ADDR_W  redirect target
- out_valid  output  1  queue head is valid
- out_instr  output  INSTR_W  instruction at the queue head
- out_pc  output  ADDR_W  PC of the queue head
- out_ready  input  1  decode accepts the head this cycle
- misalign_err  output  1  sticky misaligned-redirect flag; present only with FETCH_ALIGN_CHECK_EN

## Operation
- States: IDLE, RUN, HALT.
  - IDLE → RUN when fetch_en=1.
  - RUN → IDLE when fetch_en=0.
  - HALT exists only with the macro and is left only by reset.
- Push occurs when all of these hold: state is RUN, fetch_en=1, no redirect, and the queue is not full or a pop happens in the same cycle.
  - A push enqueues {imem_addr, imem_instr}.
  - The fetch PC is then updated to (PC+4) mod 2^ADDR_W.
- Pop occurs when out_valid and out_ready are both 1.
- Queue count range is 0..QDEPTH. A simultaneous push and pop leaves the count unchanged, including when the queue is full.
- Redirect has priority over push and pop. On a redirect:
  - Count is cleared to 0.
  - Fetch PC is loaded with redirect_pc.
  - Nothing is enqueued in that cycle.
  - A head shown in that cycle is discarded even if out_ready=1.
- Wrap-around: after the word at byte address 508 is fetched, the PC returns to 0.
- The queue is full when count=QDEPTH. In that case the PC holds and imem_addr is stable.

## Timing
- Reset values:
  - state=IDLE
  - imem_addr=RESET_PC
  - count=0, out_valid=0
  - out_instr=0, out_pc=0 (registered queue head cleared)
  - misalign_err=0
- Reset asserted mid-operation: all of the above take effect immediately (asynchronously), and any queued entries are lost.
- Fetch latency:
  - The word at PC is pushed at edge N.
  - out_valid is high after edge N when the queue was empty.
  - First instruction: in the first cycle after reset release with fetch_en=1, the state moves to RUN at edge 1. The PC 0 word is pushed at edge 2, and out_valid=1 after edge 2.
- Throughput: one instruction per cycle when out_ready is held high.
- Redirect: redirect_valid sampled at edge R.
  - After R: out_valid=0 and imem_addr=redirect_pc.
  - The target word is pushed at R+1 and valid after R+1.
- The out_* signals are stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets misalign_err at that edge.
  - The queue is flushed and the state moves to HALT.
  - No further pushes occur and the PC holds until rst_n.
- FETCH_ALIGN_CHECK_EN undefined:
  - The misalign_err port is absent.
  - redirect_pc[1:0] is ignored and forced to 00; the redirect proceeds normally.

## Structure
- Shared package fetch_pkg contains:
  - state enum (IDLE, RUN, HALT)
  - ADDR_W, INSTR_W, PC_STEP=4, RESET_PC
  - queue entry struct {pc, instr}
- One sub-module, fetch_queue: a synchronous FIFO with push, pop and flush, and count, full and empty outputs. It has no bypass path; the data output is driven from the head entry.
- The controller holds the FSM, the PC register, push/pop gating and the alignment check.

## Test plan
- Reset then fetch_en=1, out_ready=1, ROM words at 0/4/8 = 0x00500093/0x00A00113/0x002081B3 → out_valid rises after edge 2; out_pc sequence 0, 4, 8 on consecutive cycles with matching instructions.
- out_ready=0 for 5 cycles → count reaches 2; imem_addr holds at 8; out_pc stays 0. Then out_ready=1 → 0, 4, 8 delivered with no gaps or duplicates.
- redirect_valid with redirect_pc=0x40 while the queue is full → next cycle out_valid=0 and imem_addr=0x40; following cycle out_pc=0x40. The flushed entries never appear.
- Start at PC 504 via redirect → pushes at 504, 508, 0, 4 (wrap-around).
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x06 → misalign_err=1 and sticky; out_valid=0 and imem_addr frozen until rst_n. Without the macro → fetch resumes at 0x04.
- rst_n asserted asynchronously mid-stream → immediately out_valid=0, imem_addr=0. After release, fetch restarts at PC 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The misaligned-redirect check in fetch_controller is built only when
// FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Flush empties it in one edge. The head is read straight from storage, with
// no bypass, so a pushed word becomes visible one edge after it is written.
module fetch_queue #(
  parameter int DATA_W = 41,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [$clog2(QDEPTH+1)-1:0] count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH+1);

  logic [DATA_W-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;

  // Storage, pointers and occupancy. Storage is cleared on reset so the head
  // reads as zero until the first word arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop_i && !push_i) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(QDEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the fetch PC, drives the ROM address,
// queues {pc, instr} words for decode and handles stalls and redirects.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets (sticky
// misalign_err, halt until reset); otherwise target bits [1:0] are dropped.
module fetch_controller #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int QDEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               misalign_err
`endif
);

  import fetch_pkg::fetch_state_e;
  import fetch_pkg::IDLE;
  import fetch_pkg::RUN;
  import fetch_pkg::HALT;
  import fetch_pkg::PC_STEP;

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int CNT_W   = $clog2(QDEPTH+1);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               push, pop, flush, redir_ok, misaligned;
  logic               q_full, q_empty;
  logic [ENTRY_W-1:0] q_din, q_dout;
  logic [CNT_W-1:0]   unused_q_count;
  logic [ADDR_W-1:0]  redir_tgt;

  // Targets are always word aligned; the low bits only matter to the check.
  assign redir_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;

  // A misaligned target halts fetch; once halted, redirects are ignored.
  assign misaligned   = redirect_valid && (state_q != HALT) && (redirect_pc[1:0] != 2'b00);
  assign redir_ok     = redirect_valid && (state_q != HALT) && (redirect_pc[1:0] == 2'b00);
  assign misalign_err = err_q;
`else
  logic [1:0] unused_redir_lsb;

  assign unused_redir_lsb = redirect_pc[1:0];
  assign misaligned       = 1'b0;
  assign redir_ok         = redirect_valid;
`endif

  // Redirects win over both queue ports, so a head shown during a redirect is
  // dropped even if decode signals ready.
  assign flush     = redir_ok || misaligned;
  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready && !flush;
  assign push      = (state_q == RUN) && fetch_en && !redirect_valid && (!q_full || pop);
  assign q_din     = {pc_q, imem_instr};
  assign {out_pc, out_instr} = q_dout;
  assign imem_addr = pc_q;

  // Next state, next PC (and sticky error when the check is built in).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    // The PC wraps naturally at the top of the ROM.
    if (push)     pc_d = pc_q + ADDR_W'(PC_STEP);
    if (redir_ok) pc_d = redir_tgt;
`ifdef FETCH_ALIGN_CHECK_EN
    if (misaligned) begin
      state_d = HALT;
      err_d   = 1'b1;
    end
`endif
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  fetch_queue #(
    .DATA_W (ENTRY_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (q_din),
    .data_o  (q_dout),
    .count_o (unused_q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table for the main stream
// plus hand-written sequences for misaligned redirect and async reset.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [8:0]  out_pc;
  logic        out_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ROM contents: the three program words, then an address-tagged pattern.
  function automatic logic [31:0] rom_word(input logic [8:0] a);
    case (a)
      9'd0:    return 32'h0050_0093;
      9'd4:    return 32'h00A0_0113;
      9'd8:    return 32'h0020_81B3;
      default: return {8'hA5, 15'h0000, a};
    endcase
  endfunction

  assign imem_instr = rom_word(imem_addr);

  fetch_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  typedef struct {
    logic       fe;
    logic       rdy;
    logic       rv;
    logic [8:0] rpc;
    logic       ev;
    logic [8:0] epc;
    logic [8:0] eaddr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic fe, input logic rdy, input logic rv, input logic [8:0] rpc,
                     input logic ev, input logic [8:0] epc, input logic [8:0] eaddr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic ev, input logic [8:0] epc,
                       input logic [8:0] eaddr);
    logic ok;
    n_vec++;
    ok = (out_valid === ev) && (imem_addr === eaddr);
    if (ev) ok = ok && (out_pc === epc) && (out_instr === rom_word(epc));
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b pc=%h instr=%h addr=%h, want valid=%0b pc=%h instr=%h addr=%h",
               name, out_valid, out_pc, out_instr, imem_addr, ev, epc, rom_word(epc), eaddr);
    end
  endtask

  task automatic check_reset(input string name);
    logic ok;
    n_vec++;
    ok = (out_valid === 1'b0) && (imem_addr === 9'h000) && (out_pc === 9'h000) &&
         (out_instr === 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    ok = ok && (misalign_err === 1'b0);
`endif
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b addr=%h pc=%h instr=%h, want all zero",
               name, out_valid, imem_addr, out_pc, out_instr);
    end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic check_err(input string name, input logic exp);
    n_vec++;
    if (misalign_err !== exp) begin
      n_bad++;
      $display("FAIL %s: got misalign_err=%0b, want %0b", name, misalign_err, exp);
    end
  endtask
`endif

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 9'h000;
    repeat (2) @(posedge clk);
    #1 check_reset("reset_state");

    //   fe rdy rv rpc      ev epc     eaddr
    add(1, 1, 0, 9'h000,  0, 9'h000, 9'h000); // edge 1: IDLE -> RUN
    add(1, 1, 0, 9'h000,  1, 9'h000, 9'h004); // edge 2: PC 0 word visible
    add(1, 1, 0, 9'h000,  1, 9'h004, 9'h008);
    add(1, 1, 0, 9'h000,  1, 9'h008, 9'h00C);
    add(1, 1, 1, 9'h000,  0, 9'h000, 9'h000); // redirect to 0, head 8 dropped
    add(1, 0, 0, 9'h000,  1, 9'h000, 9'h004); // stall begins
    add(1, 0, 0, 9'h000,  1, 9'h000, 9'h008); // queue full
    add(1, 0, 0, 9'h000,  1, 9'h000, 9'h008);
    add(1, 0, 0, 9'h000,  1, 9'h000, 9'h008);
    add(1, 0, 0, 9'h000,  1, 9'h000, 9'h008);
    add(1, 1, 0, 9'h000,  1, 9'h004, 9'h00C); // push+pop while full
    add(1, 1, 0, 9'h000,  1, 9'h008, 9'h010);
    add(1, 0, 0, 9'h000,  1, 9'h008, 9'h010); // full again, PC holds
    add(1, 1, 1, 9'h040,  0, 9'h000, 9'h040); // redirect while full
    add(1, 1, 0, 9'h000,  1, 9'h040, 9'h044);
    add(1, 1, 0, 9'h000,  1, 9'h044, 9'h048);
    add(1, 1, 1, 9'h1F8,  0, 9'h000, 9'h1F8); // redirect near the top
    add(1, 1, 0, 9'h000,  1, 9'h1F8, 9'h1FC);
    add(1, 1, 0, 9'h000,  1, 9'h1FC, 9'h000); // wrap-around
    add(1, 1, 0, 9'h000,  1, 9'h000, 9'h004);
    add(1, 1, 0, 9'h000,  1, 9'h004, 9'h008);
    add(0, 1, 0, 9'h000,  0, 9'h000, 9'h008); // fetch disabled: RUN -> IDLE
    add(0, 1, 0, 9'h000,  0, 9'h000, 9'h008);
    add(1, 1, 0, 9'h000,  0, 9'h000, 9'h008); // IDLE -> RUN, no push yet
    add(1, 1, 0, 9'h000,  1, 9'h008, 9'h00C);

    @(negedge clk) rst_n = 1'b1;
    foreach (tv[i]) begin
      @(negedge clk);
      fetch_en = tv[i].fe; out_ready = tv[i].rdy;
      redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
      step();
      check($sformatf("vec%0d", i), tv[i].ev, tv[i].epc, tv[i].eaddr);
    end

    // Misaligned redirect target 0x06 while the head is PC 8 and PC is 12.
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 9'h006; out_ready = 1'b1; fetch_en = 1'b1;
    step();
    @(negedge clk) redirect_valid = 1'b0; redirect_pc = 9'h000;
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_halt", 1'b0, 9'h000, 9'h00C);
    check_err("misalign_set", 1'b1);
    step();
    check("misalign_hold1", 1'b0, 9'h000, 9'h00C);
    step();
    check("misalign_hold2", 1'b0, 9'h000, 9'h00C);
    check_err("misalign_sticky", 1'b1);
`else
    check("misalign_redirect", 1'b0, 9'h000, 9'h004);
    step();
    check("misalign_resume4", 1'b1, 9'h004, 9'h008);
    step();
    check("misalign_resume8", 1'b1, 9'h008, 9'h00C);
`endif

    // Asynchronous reset in the middle of a cycle, then a clean restart.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    check("restart_idle", 1'b0, 9'h000, 9'h000);
    step();
    check("restart_pc0", 1'b1, 9'h000, 9'h004);
    step();
    check("restart_pc4", 1'b1, 9'h004, 9'h008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
